// File: rtl/int_alu_mc.sv
// int_alu_mc: multi-cycle integer ALU with single-cycle ops, a radix-2 shift-add
// multiplier and an optional restoring divider (compiled in by `define INT_ALU_DIV_EN).
module int_alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ovf,
    output logic             dz,
    output logic             ill,
    output logic [1:0]       dbg_state_o
);

    // Handshake: an op is taken on a rising edge of c with in_valid && in_ready; a result
    // is presented with out_valid, held stable while !out_ready, and retired on out_valid && out_ready.

    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_ADDU  = 6'b100001;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_SUBU  = 6'b100011;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;
    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_SLLV  = 6'b000100;
    localparam logic [5:0] OP_SRLV  = 6'b000110;
    localparam logic [5:0] OP_SRAV  = 6'b000111;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
`ifdef INT_ALU_DIV_EN
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef INT_ALU_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   result_q, hi_q, lo_q;
    logic               ovf_q, dz_q, ill_q;
    logic [SHW-1:0]     cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic               neg_q;
    logic               last_iter;
    logic               is_mul, mul_sgn;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign mul_sgn   = (op == OP_MULT);
    assign last_iter = (cnt_q == SHW'(WIDTH - 1));

    // Single-cycle datapath
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic [SHW-1:0]   shamt;
    logic             alu_ovf, alu_ill;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = a[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU:          alu_res = diff;
            OP_AND:           alu_res = a & b;
            OP_OR:            alu_res = a | b;
            OP_XOR:           alu_res = a ^ b;
            OP_NOR:           alu_res = ~(a | b);
            OP_SLT:           alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:          alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL, OP_SLLV:  alu_res = b << shamt;
            OP_SRL, OP_SRLV:  alu_res = b >> shamt;
            OP_SRA, OP_SRAV:  alu_res = $unsigned($signed(b) >>> shamt);
            default:          alu_ill = 1'b1;
        endcase
    end

    // Multiplier step: acc holds {partial sum, remaining multiplier bits}
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_fin;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign mul_fin  = neg_q ? -mul_next : mul_next;

`ifdef INT_ALU_DIV_EN
    // Divider step: acc holds {partial remainder, dividend bits turning into quotient bits}
    logic               is_div, div_sgn, neg_r_q, dovf_q;
    logic [WIDTH:0]     rem_sh, rem_try;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fin, rem_fin;

    assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
    assign div_sgn  = (op == OP_DIV);
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_try  = rem_sh - {1'b0, mcand_q};
    assign div_next = rem_try[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {rem_try[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign quo_fin  = neg_q   ? -div_next[WIDTH-1:0]       : div_next[WIDTH-1:0];
    assign rem_fin  = neg_r_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
`endif

    // FSM: state register
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_mul) begin
                        state_d = S_MUL;
`ifdef INT_ALU_DIV_EN
                    end else if (is_div && (b != '0)) begin
                        state_d = S_DIV;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: if (last_iter) state_d = S_DONE;
`ifdef INT_ALU_DIV_EN
            S_DIV: if (last_iter) state_d = S_DONE;
`endif
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs; in_ready is masked while reset is held
    always_comb begin
        in_ready    = (state_q == S_IDLE) && rst_n;
        out_valid   = (state_q == S_DONE);
        dbg_state_o = state_q;
    end

    // Datapath registers
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
`ifdef INT_ALU_DIV_EN
            neg_r_q  <= 1'b0;
            dovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        cnt_q <= '0;
                        ovf_q <= 1'b0;
                        dz_q  <= 1'b0;
                        ill_q <= 1'b0;
                        if (is_mul) begin
                            mcand_q <= mul_sgn ? mag(a) : a;
                            acc_q   <= {{WIDTH{1'b0}}, (mul_sgn ? mag(b) : b)};
                            neg_q   <= mul_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef INT_ALU_DIV_EN
                        end else if (is_div) begin
                            if (b == '0) begin
                                dz_q     <= 1'b1;
                                lo_q     <= '1;
                                hi_q     <= a;
                                result_q <= '1;
                            end else begin
                                // Most-negative / -1 falls out of the magnitude path; only the flag is special.
                                mcand_q <= div_sgn ? mag(b) : b;
                                acc_q   <= {{WIDTH{1'b0}}, (div_sgn ? mag(a) : a)};
                                neg_q   <= div_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r_q <= div_sgn && a[WIDTH-1];
                                dovf_q  <= div_sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
                            end
`endif
                        end else begin
                            result_q <= alu_res;
                            ovf_q    <= alu_ovf;
                            ill_q    <= alu_ill;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        hi_q     <= mul_fin[2*WIDTH-1:WIDTH];
                        lo_q     <= mul_fin[WIDTH-1:0];
                        result_q <= mul_fin[WIDTH-1:0];
                    end
                end
`ifdef INT_ALU_DIV_EN
                S_DIV: begin
                    acc_q <= div_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        lo_q     <= quo_fin;
                        hi_q     <= rem_fin;
                        result_q <= quo_fin;
                        ovf_q    <= dovf_q;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign ovf    = ovf_q;
    assign dz     = dz_q;
    assign ill    = ill_q;

endmodule
